// File: rtl/noc_pkg.sv
// Shared widths and helpers for the NoC ingress arbiter.
package noc_pkg;

   localparam int DATA_W = 64;

   typedef logic [DATA_W-1:0] data_t;

   // Index width for CPU and pointer fields; a single CPU still gets one bit.
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/noc_rr_pick.sv
// Rotating priority picker: first set request at or after ptr, wrapping around.
module noc_rr_pick
   import noc_pkg::*;
#(
   parameter int N  = 4,
   parameter int PW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic          any,
   output logic [PW-1:0] win
);

   // Scan from the farthest offset back toward ptr so the nearest request is assigned last.
   always_comb begin
      logic [PW-1:0] idx;
      any = 1'b0;
      win = '0;
      idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = PW'((int'(ptr) + k) % N);
         if (req[idx]) begin
            any = 1'b1;
            win = idx;
         end
      end
   end

endmodule

// File: rtl/noc_arbiter.sv
// Round-robin arbiter with bounded burst ownership, merging CPU beats into one
// registered NoC ingress stage tagged with the source index.
module noc_arbiter
   import noc_pkg::*;
#(
   parameter int CPU_NB    = 4,
   parameter int MAX_BURST = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [CPU_NB-1:0]          cpu_data_vld,
   input  logic [CPU_NB*DATA_W-1:0]   cpu_data,
   output logic [CPU_NB-1:0]          cpu_data_rdy,
   output logic                       out_vld,
   output logic [DATA_W-1:0]          out_data,
   output logic [idx_w(CPU_NB)-1:0]   out_src,
   input  logic                       out_rdy
);

   localparam int IW = idx_w(CPU_NB);
   localparam int BW = idx_w(MAX_BURST);

   logic [IW-1:0]     ptr;
   logic [IW-1:0]     ptr_nxt;
   logic [BW-1:0]     burst_cnt;
   logic [BW-1:0]     cnt_nxt;
   logic              any;
   logic [IW-1:0]     win;
   logic [IW-1:0]     win_inc;
   logic [CPU_NB-1:0] win_oh;
   logic              accept;
   logic              xfer;
   logic              others;
   data_t             sel_data;

   noc_rr_pick #(
      .N  (CPU_NB),
      .PW (IW)
   ) u_pick (
      .req (cpu_data_vld),
      .ptr (ptr),
      .any (any),
      .win (win)
   );

   assign accept   = !out_vld || out_rdy;
   assign xfer     = accept && any;
   assign win_oh   = CPU_NB'(1) << win;
   assign win_inc  = (int'(win) == CPU_NB - 1) ? '0 : win + IW'(1);
   assign sel_data = cpu_data[int'(win)*DATA_W +: DATA_W];
   assign others   = |(cpu_data_vld & ~win_oh);

   // Grants are masked during reset even though the pointer logic would already pick.
   assign cpu_data_rdy = (xfer && !rst) ? win_oh : '0;

   always_comb begin
      ptr_nxt = ptr;
      cnt_nxt = burst_cnt;
      if (xfer) begin
         if (win != ptr) begin
            if (MAX_BURST == 1) begin
               ptr_nxt = win_inc;
               cnt_nxt = '0;
            end else begin
               ptr_nxt = win;
               cnt_nxt = BW'(1);
            end
         end else if (int'(burst_cnt) + 1 == MAX_BURST) begin
            ptr_nxt = win_inc;
            cnt_nxt = '0;
         end else begin
            cnt_nxt = burst_cnt + BW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr       <= '0;
         burst_cnt <= '0;
      end else begin
         ptr       <= ptr_nxt;
         burst_cnt <= cnt_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_vld  <= 1'b0;
         out_data <= '0;
         out_src  <= '0;
      end else if (xfer) begin
         out_vld  <= 1'b1;
         out_data <= sel_data;
         out_src  <= win;
      end else if (out_rdy) begin
         out_vld  <= 1'b0;
      end
   end

   // Length of the current run of contended beats won by the same CPU.
   int            run_cnt;
   logic [IW-1:0] run_src;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_cnt <= 0;
         run_src <= '0;
      end else if (xfer) begin
         if (!others)
            run_cnt <= 0;
         else if (run_cnt != 0 && win == run_src)
            run_cnt <= run_cnt + 1;
         else
            run_cnt <= 1;
         run_src <= win;
      end
   end

   a_rdy_onehot0: assert property (@(posedge clk) disable iff (rst)
      $onehot0(cpu_data_rdy));

   a_stall_stable: assert property (@(posedge clk) disable iff (rst)
      out_vld && !out_rdy |=> $stable(out_data) && $stable(out_src));

   a_burst_bound: assert property (@(posedge clk) disable iff (rst)
      xfer && others && run_cnt != 0 && win == run_src |-> run_cnt < MAX_BURST);

endmodule

// File: tb/tb_noc_arbiter.sv
// Bench for noc_arbiter: MAX_BURST=2 and MAX_BURST=1 instances on shared stimulus,
// each checked every cycle against a per-instance arbitration model.
module tb_noc_arbiter;
   import noc_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   cpu_vld;
   logic [63:0]  data_arr [4];
   logic [255:0] cpu_data;
   logic         out_rdy;

   logic [3:0]   rdy0, rdy1;
   logic         ovld0, ovld1;
   logic [63:0]  odat0, odat1;
   logic [1:0]   osrc0, osrc1;

   always #5 clk = ~clk;

   always_comb begin
      cpu_data = '0;
      for (int i = 0; i < 4; i++) cpu_data[i*64 +: 64] = data_arr[i];
   end

   noc_arbiter #(.CPU_NB(4), .MAX_BURST(2)) dut (
      .clk(clk), .rst(rst), .cpu_data_vld(cpu_vld), .cpu_data(cpu_data),
      .cpu_data_rdy(rdy0), .out_vld(ovld0), .out_data(odat0), .out_src(osrc0),
      .out_rdy(out_rdy));

   noc_arbiter #(.CPU_NB(4), .MAX_BURST(1)) dut1 (
      .clk(clk), .rst(rst), .cpu_data_vld(cpu_vld), .cpu_data(cpu_data),
      .cpu_data_rdy(rdy1), .out_vld(ovld1), .out_data(odat1), .out_src(osrc1),
      .out_rdy(out_rdy));

   int total = 0;
   int bad   = 0;

   int          mb    [2] = '{2, 1};
   int          m_ptr [2];
   int          m_cnt [2];
   int          m_src [2];
   bit          m_vld [2];
   logic [63:0] m_dat [2];
   bit          xfer_d[2];
   int          win_d [2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic reset_model();
      for (int m = 0; m < 2; m++) begin
         m_ptr[m] = 0; m_cnt[m] = 0; m_src[m] = 0; m_vld[m] = 0; m_dat[m] = '0;
      end
   endtask

   function automatic int pick(input int p);
      for (int k = 0; k < 4; k++) begin
         int i;
         i = (p + k) % 4;
         if (cpu_vld[i]) return i;
      end
      return -1;
   endfunction

   // One clock: check outputs against the model, take the edge, advance the model.
   task automatic cyc();
      logic [3:0] er;
      #1;
      for (int m = 0; m < 2; m++) begin
         win_d[m]  = pick(m_ptr[m]);
         xfer_d[m] = (!m_vld[m] || out_rdy) && (win_d[m] >= 0);
         er = xfer_d[m] ? (4'b0001 << win_d[m]) : 4'b0000;
         chk(m == 0 ? "rdy_mb2" : "rdy_mb1", m == 0 ? rdy0 : rdy1, er);
         chk(m == 0 ? "vld_mb2" : "vld_mb1", m == 0 ? ovld0 : ovld1, m_vld[m]);
         chk(m == 0 ? "dat_mb2" : "dat_mb1", m == 0 ? odat0 : odat1, m_dat[m]);
         chk(m == 0 ? "src_mb2" : "src_mb1", m == 0 ? osrc0 : osrc1, m_src[m]);
      end
      chk("ptr_mb2", dut.ptr, m_ptr[0]);
      chk("cnt_mb2", dut.burst_cnt, m_cnt[0]);
      chk("ptr_mb1", dut1.ptr, m_ptr[1]);
      @(posedge clk);
      for (int m = 0; m < 2; m++) begin
         if (xfer_d[m]) begin
            int w;
            w = win_d[m];
            m_vld[m] = 1; m_dat[m] = data_arr[w]; m_src[m] = w;
            if (w != m_ptr[m]) begin
               if (mb[m] == 1) begin m_ptr[m] = (w + 1) % 4; m_cnt[m] = 0; end
               else begin m_ptr[m] = w; m_cnt[m] = 1; end
            end else if (m_cnt[m] + 1 == mb[m]) begin
               m_ptr[m] = (w + 1) % 4; m_cnt[m] = 0;
            end else begin
               m_cnt[m]++;
            end
         end else if (out_rdy) begin
            m_vld[m] = 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic async_reset();
      rst = 1'b1;
      #1;
      chk("arst_vld_mb2", ovld0, 0);
      chk("arst_dat_mb2", odat0, 0);
      chk("arst_vld_mb1", ovld1, 0);
      chk("arst_rdy_mb2", rdy0, 0);
      chk("arst_rdy_mb1", rdy1, 0);
      reset_model();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int prev;
      int sv_ptr, sv_cnt;
      rst = 1'b1; cpu_vld = 4'hF; out_rdy = 1'b1;
      for (int i = 0; i < 4; i++) data_arr[i] = 64'h100 * (i + 1);
      reset_model();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_rdy", rdy0, 0);
      chk("rst_vld", ovld0, 0);
      chk("rst_dat", odat0, 0);
      chk("rst_src", osrc0, 0);
      chk("rst_ptr", dut.ptr, 0);
      @(negedge clk);
      rst = 1'b0;

      // all CPUs streaming
      for (int n = 0; n < 16; n++) begin
         cyc();
         chk("s1_seq_mb2", osrc0, (n / 2) % 4);
         chk("s1_seq_mb1", osrc1, n % 4);
      end

      // lone CPU2 stream, no bubbles
      cpu_vld = 4'b0100;
      data_arr[2] = 64'hA0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk("s2_vld", ovld0, 1);
         chk("s2_dat", odat0, 64'hA0 + i);
         chk("s2_src", osrc0, 2);
         if (xfer_d[0]) data_arr[2] = data_arr[2] + 1;
      end

      // stall with CPU3 waiting
      cpu_vld = 4'b0010; data_arr[1] = 64'h1111;
      cyc();
      chk("s3_first", odat0, 64'h1111);
      cpu_vld = 4'b1000; data_arr[3] = 64'h3333; out_rdy = 1'b0;
      repeat (3) begin
         cyc();
         chk("s3_hold", odat0, 64'h1111);
         chk("s3_rdy0", rdy0, 0);
      end
      out_rdy = 1'b1;
      #1;
      chk("s3_release_rdy", rdy0, 4'b1000);
      cyc();
      chk("s3_cpu3", odat0, 64'h3333);

      // CPUs 0 and 3 on the pure round-robin instance
      cpu_vld = 4'b1001;
      prev = -1;
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (prev >= 0) chk("s4_alt", osrc1, (prev == 0) ? 3 : 0);
         prev = int'(osrc1);
      end

      // async reset with a beat in flight
      cpu_vld = 4'b0001; data_arr[0] = 64'hDEAD;
      cyc();
      chk("s5_dead", odat0, 64'hDEAD);
      cpu_vld = 4'b0110;
      async_reset();
      cyc();
      chk("s5_first_mb2", osrc0, 1);
      chk("s5_first_mb1", osrc1, 1);

      // idle gap mid-burst
      cpu_vld = 4'b0000;
      sv_ptr = int'(dut.ptr);
      sv_cnt = int'(dut.burst_cnt);
      chk("s6_mid_burst", dut.burst_cnt, 1);
      repeat (10) begin
         cyc();
         chk("s6_ptr", dut.ptr, sv_ptr);
         chk("s6_cnt", dut.burst_cnt, sv_cnt);
      end
      chk("s6_drained", ovld0, 0);
      cpu_vld = 4'b0110;
      cyc();
      chk("s6_resume", osrc0, 1);
      repeat (3) cyc();

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         cpu_vld = 4'($urandom);
         for (int i = 0; i < 4; i++) data_arr[i] = {$urandom, $urandom};
         out_rdy = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 299) == 0) async_reset();
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
